// File: rtl/pwm_bus_slave_if.sv
// Data-bus request/grant/rvalid channel between the address decoder slot and
// one peripheral.
interface pwm_bus_slave_if;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/pwm_bus_slave.sv
// Bus-mapped register bank plus a shared-period, two-channel PWM generator
// for the chassis motors.
module pwm_bus_slave #(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned OFFS_W = 5
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  pwm_bus_slave_if.slave bus,
  output logic           pwm0_o,
  output logic           pwm1_o,
  output logic           irq_o
);

  localparam int unsigned IdxW = OFFS_W - 2;
  typedef logic [IdxW-1:0]  idx_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam idx_t IdxCtrl   = idx_t'(0);
  localparam idx_t IdxPeriod = idx_t'(1);
  localparam idx_t IdxDuty0  = idx_t'(2);
  localparam idx_t IdxDuty1  = idx_t'(3);
  localparam idx_t IdxCnt    = idx_t'(4);
  localparam idx_t IdxStatus = idx_t'(5);

  logic [3:0]  ctrl_q, ctrl_d;
  cnt_t        period_q, period_d, duty0_q, duty0_d, duty1_q, duty1_d;
  cnt_t        period_act_q, period_act_d;
  cnt_t        duty0_act_q, duty0_act_d, duty1_act_q, duty1_act_d;
  cnt_t        cnt_q, cnt_d;
  logic        wrap_q, wrap_d;
  logic        pwm0_q, pwm0_d, pwm1_q, pwm1_d;
  logic        rvalid_q, rvalid_d, err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  idx_t idx;
  logic wr;
  logic en;
  logic wrap_evt;
  logic unused_addr;

  assign idx         = bus.addr[OFFS_W-1:2];
  assign wr          = bus.req & bus.we;
  assign en          = ctrl_q[0];
  assign wrap_evt    = en && (cnt_q == period_act_q);
  assign unused_addr = ^{bus.addr[31:OFFS_W], bus.addr[1:0]};

  function automatic logic [31:0] merge_be(logic [31:0] old, logic [31:0] wd, logic [3:0] be);
    for (int b = 0; b < 4; b++) begin
      merge_be[8*b +: 8] = be[b] ? wd[8*b +: 8] : old[8*b +: 8];
    end
  endfunction

  always_comb begin : reg_write
    ctrl_d   = ctrl_q;
    period_d = period_q;
    duty0_d  = duty0_q;
    duty1_d  = duty1_q;
    wrap_d   = wrap_q;
    if (wr) begin
      case (idx)
        IdxCtrl:   if (bus.be[0]) ctrl_d = bus.wdata[3:0];
        IdxPeriod: period_d = cnt_t'(merge_be(32'(period_q), bus.wdata, bus.be));
        IdxDuty0:  duty0_d  = cnt_t'(merge_be(32'(duty0_q), bus.wdata, bus.be));
        IdxDuty1:  duty1_d  = cnt_t'(merge_be(32'(duty1_q), bus.wdata, bus.be));
        IdxStatus: if (bus.be[0] && bus.wdata[0]) wrap_d = 1'b0;
        default:   ;
      endcase
    end
    // A wrap in the same cycle as a clear keeps WRAP set.
    if (wrap_evt) wrap_d = 1'b1;
  end

  always_comb begin : counter
    cnt_d        = cnt_q + cnt_t'(1);
    period_act_d = period_act_q;
    duty0_act_d  = duty0_act_q;
    duty1_act_d  = duty1_act_q;
    // Looking at ctrl_d lets a disabling write zero the count on the very next cycle.
    if (!en || !ctrl_d[0] || wrap_evt) cnt_d = '0;
    // Actives sample the shadows as they stood before any write in this cycle.
    if (!en || wrap_evt) begin
      period_act_d = period_q;
      duty0_act_d  = duty0_q;
      duty1_act_d  = duty1_q;
    end
    pwm0_d = en & ctrl_q[1] & (cnt_q < duty0_act_q);
    pwm1_d = en & ctrl_q[2] & (cnt_q < duty1_act_q);
  end

  always_comb begin : response
    rvalid_d = bus.req;
    rdata_d  = '0;
    err_d    = 1'b0;
    if (bus.req) begin
      case (idx)
        IdxCtrl:   rdata_d = 32'(ctrl_q);
        IdxPeriod: rdata_d = 32'(period_q);
        IdxDuty0:  rdata_d = 32'(duty0_q);
        IdxDuty1:  rdata_d = 32'(duty1_q);
        IdxCnt: begin
          rdata_d = 32'(cnt_q);
          err_d   = bus.we;
        end
        IdxStatus: rdata_d = 32'(wrap_q);
        default:   err_d = 1'b1;
      endcase
      if (bus.we) rdata_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_q       <= '0;
      period_q     <= '0;
      duty0_q      <= '0;
      duty1_q      <= '0;
      period_act_q <= '0;
      duty0_act_q  <= '0;
      duty1_act_q  <= '0;
      cnt_q        <= '0;
      wrap_q       <= 1'b0;
      pwm0_q       <= 1'b0;
      pwm1_q       <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      ctrl_q       <= ctrl_d;
      period_q     <= period_d;
      duty0_q      <= duty0_d;
      duty1_q      <= duty1_d;
      period_act_q <= period_act_d;
      duty0_act_q  <= duty0_act_d;
      duty1_act_q  <= duty1_act_d;
      cnt_q        <= cnt_d;
      wrap_q       <= wrap_d;
      pwm0_q       <= pwm0_d;
      pwm1_q       <= pwm1_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  assign bus.gnt    = bus.req;
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;
  assign bus.err    = err_q;
  assign pwm0_o     = pwm0_q;
  assign pwm1_o     = pwm1_q;
  assign irq_o      = wrap_q & ctrl_q[3];

endmodule

// File: tb/tb_pwm_bus_slave.sv
// Directed plus randomized bench for pwm_bus_slave; expectations come from a
// cycle-count model of the PWM timing and a byte-lane model of the registers.
module tb_pwm_bus_slave;
  localparam int unsigned CntW = 16;
  localparam logic [31:0] Mask = 32'h0000_FFFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pwm0, pwm1, irq;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int en_cyc = 0;
  int dw_cyc = 1 << 30;

  logic [31:0] rd_data;
  logic        rd_err;
  logic        rd_valid;
  logic [31:0] shadow [4];

  pwm_bus_slave_if bus ();

  pwm_bus_slave #(.CNT_W(CntW), .OFFS_W(5)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus),
    .pwm0_o(pwm0),
    .pwm1_o(pwm1),
    .irq_o (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One bus transfer: request in the current cycle, response captured next cycle.
  task automatic op(input logic w, input logic [31:0] a, input logic [3:0] b,
                    input logic [31:0] d);
    bus.req   = 1'b1;
    bus.we    = w;
    bus.addr  = a;
    bus.be    = b;
    bus.wdata = d;
    #1;
    chk("gnt", 32'(bus.gnt), 32'd1);
    @(posedge clk);
    #1;
    bus.req  = 1'b0;
    bus.we   = 1'b0;
    rd_valid = bus.rvalid;
    rd_data  = bus.rdata;
    rd_err   = bus.err;
    chk("rvalid", 32'(rd_valid), 32'd1);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp,
                        input logic exp_err);
    op(1'b0, a, 4'h0, $urandom);
    chk({tag, ".data"}, rd_data, exp);
    chk({tag, ".err"}, 32'(rd_err), 32'(exp_err));
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
    op(1'b1, a, b, d);
  endtask

  task automatic wait_cnt(input int target);
    for (int i = 0; i < 32 && ((cyc - en_cyc) % 10) != target; i++) step();
  endtask

  function automatic logic [31:0] merge_model(logic [31:0] old, logic [31:0] d, logic [3:0] b);
    logic [31:0] m;
    m = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
    return (old & ~m) | (d & m);
  endfunction

  // Period 10 cycles from en_cyc; DUTY0 goes 3 -> 7 at the first period whose
  // preceding wrap cycle came after the shadow write at dw_cyc.
  function automatic logic exp_pwm0(int n);
    int cp, start, duty;
    cp    = (n - 1 - en_cyc) % 10;
    start = n - 1 - cp;
    duty  = (start - 1 >= dw_cyc + 1) ? 7 : 3;
    return cp < duty;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          c, hi_cnt;
    int unsigned k, k2;
    logic [31:0] d, hi;
    logic [3:0]  b;

    bus.req = 1'b1; bus.we = 1'b0; bus.be = 4'h0; bus.addr = '0; bus.wdata = '0;
    for (int i = 0; i < 4; i++) shadow[i] = '0;

    // Reset with a request pending
    repeat (3) @(posedge clk);
    #1;
    chk("rst.gnt", 32'(bus.gnt), 32'd1);
    chk("rst.rvalid", 32'(bus.rvalid), 32'd0);
    chk("rst.rdata", bus.rdata, 32'd0);
    chk("rst.err", 32'(bus.err), 32'd0);
    chk("rst.pwm0", 32'(pwm0), 32'd0);
    chk("rst.pwm1", 32'(pwm1), 32'd0);
    chk("rst.irq", 32'(irq), 32'd0);
    bus.req = 1'b0;
    rst_n   = 1'b1;
    step();
    rd_chk("ctrl_rst", 32'h0, 32'h0, 1'b0);

    // Directed register access
    wr(32'h4, 4'b0011, 32'h0000_0009);
    chk("wr.rdata", rd_data, 32'h0);
    chk("wr.err", 32'(rd_err), 32'd0);
    rd_chk("period", 32'h4, 32'h9, 1'b0);
    wr(32'h8, 4'b0100, 32'h1234_5678);
    rd_chk("duty0_hi", 32'h8, 32'h0, 1'b0);
    rd_chk("bad_off", 32'h18, 32'h0, 1'b1);
    wr(32'h10, 4'hF, 32'h5);
    chk("cnt_wr.err", 32'(rd_err), 32'd1);
    rd_chk("cnt_ro", 32'h10, 32'h0, 1'b0);
    // Back-to-back read / write / read
    rd_chk("b2b0", 32'h0, 32'h0, 1'b0);
    wr(32'hC, 4'hF, 32'h55);
    rd_chk("b2b2", 32'hC, 32'h55, 1'b0);
    step();
    chk("idle.rvalid", 32'(bus.rvalid), 32'd0);
    chk("idle.rdata", bus.rdata, 32'd0);
    shadow[1] = 32'h9;
    shadow[3] = 32'h55;

    // Randomized register traffic with EN held low
    for (int i = 0; i < 24; i++) begin
      k  = $urandom_range(0, 3);
      k2 = $urandom_range(0, 3);
      hi = $urandom & 32'hFFFF_FFE0;
      d  = $urandom;
      b  = 4'($urandom);
      if (k == 0) begin
        d[0] = 1'b0;
        if (b[0]) shadow[0] = d & 32'hF;
      end else begin
        shadow[k] = merge_model(shadow[k], d, b) & Mask;
      end
      wr(hi | 32'(k * 4), b, d);
      chk("rnd_wr.err", 32'(rd_err), 32'd0);
      wr(hi | 32'(24 + 4 * $urandom_range(0, 1)), 4'hF, $urandom);
      chk("rnd_badwr.err", 32'(rd_err), 32'd1);
      rd_chk("rnd_rd", ($urandom & 32'hFFFF_FFE0) | 32'(k2 * 4), shadow[k2], 1'b0);
    end
    rd_chk("rnd_status", 32'h14, 32'h0, 1'b0);

    // PWM waveform: period 10 cycles, duty0 3, duty1 above period
    wr(32'h4, 4'hF, 32'd9);
    wr(32'h8, 4'hF, 32'd3);
    wr(32'hC, 4'hF, 32'd10);
    wr(32'h0, 4'hF, 32'h7);
    en_cyc = cyc;
    for (int i = 0; i < 20; i++) begin
      c = cyc;
      rd_chk("cnt_run", 32'h10, 32'((c - en_cyc) % 10), 1'b0);
    end
    hi_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      chk("pwm0", 32'(pwm0), 32'(exp_pwm0(cyc)));
      chk("pwm1", 32'(pwm1), 32'd1);
      hi_cnt += int'(pwm0);
      step();
    end
    chk("pwm0_highs", 32'(hi_cnt), 32'd6);

    // Shadow DUTY0 update mid-period
    wait_cnt(5);
    dw_cyc = cyc;
    wr(32'h8, 4'hF, 32'd7);
    for (int i = 0; i < 25; i++) begin
      chk("pwm0_shadow", 32'(pwm0), 32'(exp_pwm0(cyc)));
      step();
    end

    // Disable at cnt=5
    wait_cnt(5);
    wr(32'h0, 4'hF, 32'h6);
    chk("dis.pwm0_hold", 32'(pwm0), 32'(exp_pwm0(cyc)));
    chk("dis.pwm1_hold", 32'(pwm1), 32'd1);
    rd_chk("dis.cnt", 32'h10, 32'h0, 1'b0);
    chk("dis.pwm0", 32'(pwm0), 32'd0);
    chk("dis.pwm1", 32'(pwm1), 32'd0);
    rd_chk("dis.period", 32'h4, 32'd9, 1'b0);
    rd_chk("dis.duty0", 32'h8, 32'd7, 1'b0);
    rd_chk("dis.duty1", 32'hC, 32'd10, 1'b0);
    rd_chk("dis.ctrl", 32'h0, 32'h6, 1'b0);
    rd_chk("dis.status", 32'h14, 32'h1, 1'b0);
    wr(32'h14, 4'h1, 32'h1);
    rd_chk("clr.status", 32'h14, 32'h0, 1'b0);

    // Interrupt: rises the cycle after the first wrap
    wr(32'h0, 4'hF, 32'hF);
    en_cyc = cyc;
    for (int i = 0; i <= 10; i++) begin
      chk("irq_rise", 32'(irq), 32'(i == 10));
      if (i < 10) step();
    end
    wait_cnt(9);
    wr(32'h14, 4'h1, 32'h1);
    chk("irq_wrap_clr", 32'(irq), 32'd1);
    rd_chk("status_wrap_clr", 32'h14, 32'h1, 1'b0);
    wait_cnt(3);
    wr(32'h14, 4'h1, 32'h1);
    chk("irq_clr", 32'(irq), 32'd0);
    rd_chk("status_clr", 32'h14, 32'h0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
